// File: rtl/regdecr_pipe_valrdy.sv
// regdecr_pipe_valrdy: elastic NSTAGES-deep registered decrementer, out_msg = in_msg - NSTAGES (mod 2^NBITS).
// Latency: NSTAGES cycles from input acceptance to out_val; one message per cycle while out_rdy stays high.
// Backpressure: a stage advances when it is empty or the stage ahead advances; bubbles collapse, in_rdy depends combinationally on out_rdy.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_val/in_rdy/in_msg producer side handshake and data
//   out_val/out_rdy/out_msg consumer side handshake and data (registered)
//   occupancy            number of stages currently holding a valid message
module regdecr_pipe_valrdy #(
  parameter int NBITS   = 8,
  parameter int NSTAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [NBITS-1:0]             in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [NBITS-1:0]             out_msg,
  output logic [$clog2(NSTAGES+1)-1:0] occupancy
);

  localparam int                OCCW = $clog2(NSTAGES + 1);
  localparam logic [NBITS-1:0]  ONE  = NBITS'(1);

  // Per-stage state.
  logic [NSTAGES-1:0] valid_q;
  logic [NBITS-1:0]   data_q [NSTAGES];

  // Advance enables and the message presented to each stage from upstream.
  logic [NSTAGES-1:0] go;
  logic [NSTAGES-1:0] up_valid;
  logic [NBITS-1:0]   up_data [NSTAGES];
  logic [OCCW-1:0]    occ_cnt;

  // A stage may load when it is empty or its occupant moves on this edge.
  // Walking from the output back to stage 0 with a running flag keeps the
  // chain free of self-referencing vector bits.
  always_comb begin
    logic room;
    go   = '0;
    room = out_rdy;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      room  = !valid_q[i] || room;
      go[i] = room;
    end
  end

  // Stage 0 is fed by the input port, every later stage by its predecessor.
  always_comb begin
    up_valid = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      up_data[i] = '0;
    end
    up_valid[0] = in_val;
    up_data[0]  = in_msg;
    for (int i = 1; i < NSTAGES; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  // Each stage subtracts one as it captures. Data is only rewritten when a
  // valid message arrives, so a stage that empties keeps its old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NSTAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSTAGES; i++) begin
        if (go[i]) begin
          valid_q[i] <= up_valid[i];
          if (up_valid[i]) begin
            data_q[i] <= up_data[i] - ONE;
          end
        end
      end
    end
  end

  // Occupancy is a population count of the stage valid registers.
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      occ_cnt = occ_cnt + OCCW'(valid_q[i]);
    end
  end

  assign in_rdy    = go[0] && !reset;
  assign out_val   = valid_q[NSTAGES-1];
  assign out_msg   = data_q[NSTAGES-1];
  assign occupancy = occ_cnt;

  // A stalled output must hold its message until it is taken.
  a_stall_hold : assert property (@(posedge clk)
    (out_val && !out_rdy && !reset) |=> (out_val && $stable(out_msg)));

endmodule

// File: tb/tb_regdecr_pipe_valrdy.sv
// tb_regdecr_pipe_valrdy: directed and randomized checks of three pipe depths (1, 2, 4).
// The reference model tracks which slots hold a message and a FIFO of expected outputs (input - depth).
module tb_regdecr_pipe_valrdy;

  localparam int NI = 3;   // instance 0: NSTAGES=1, 1: NSTAGES=2, 2: NSTAGES=4
  localparam int K2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [NI];
  logic       in_val  [NI];
  logic [7:0] in_msg  [NI];
  logic       out_rdy [NI];
  logic       in_rdy  [NI];
  logic       out_val [NI];
  logic [7:0] out_msg [NI];
  logic [0:0] occ_s1;
  logic [1:0] occ_s2;
  logic [2:0] occ_s4;

  int total = 0;
  int bad   = 0;

  regdecr_pipe_valrdy #(.NBITS(8), .NSTAGES(1)) u_s1 (
    .clk(clk), .reset(rst[0]), .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_msg(in_msg[0]),
    .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg[0]), .occupancy(occ_s1));
  regdecr_pipe_valrdy #(.NBITS(8), .NSTAGES(2)) u_s2 (
    .clk(clk), .reset(rst[1]), .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_msg(in_msg[1]),
    .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg[1]), .occupancy(occ_s2));
  regdecr_pipe_valrdy #(.NBITS(8), .NSTAGES(4)) u_s4 (
    .clk(clk), .reset(rst[2]), .in_val(in_val[2]), .in_rdy(in_rdy[2]), .in_msg(in_msg[2]),
    .out_val(out_val[2]), .out_rdy(out_rdy[2]), .out_msg(out_msg[2]), .occupancy(occ_s4));

  function automatic int ns_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic int occ_of(input int k);
    case (k)
      0:       return int'(occ_s1);
      1:       return int'(occ_s2);
      default: return int'(occ_s4);
    endcase
  endfunction

  // ---------------- reference model ----------------
  bit         slot    [NI][8];    // slot j holds a message
  logic [7:0] sb      [NI][16];   // expected outputs in order
  int         sb_head [NI];
  int         sb_cnt  [NI];

  // The entry slot can take a message if it is empty or its occupant can move on;
  // the last slot's occupant moves on when the consumer is ready.
  function automatic bit model_in_rdy(input int k);
    bit acc;
    if (rst[k]) return 1'b0;
    acc = out_rdy[k];
    for (int j = ns_of(k) - 1; j >= 0; j--) acc = !slot[k][j] || acc;
    return acc;
  endfunction

  function automatic bit model_out_val(input int k);
    return slot[k][ns_of(k) - 1];
  endfunction

  function automatic int model_occ(input int k);
    int c = 0;
    for (int j = 0; j < ns_of(k); j++) c += int'(slot[k][j]);
    return c;
  endfunction

  // Advance every model by one clock using the current inputs, then clock the DUTs.
  task automatic tick();
    for (int k = 0; k < NI; k++) begin
      int n;
      bit acc [9];
      bit nxt [8];
      n = ns_of(k);
      acc[n] = out_rdy[k];
      for (int j = n - 1; j >= 0; j--) acc[j] = !slot[k][j] || acc[j+1];
      for (int j = 0; j < 8; j++) nxt[j] = 1'b0;
      if (rst[k]) begin
        sb_head[k] = 0;
        sb_cnt[k]  = 0;
      end else begin
        if (slot[k][n-1] && out_rdy[k]) begin
          sb_head[k] = (sb_head[k] + 1) % 16;
          sb_cnt[k]  = sb_cnt[k] - 1;
        end
        for (int j = 0; j < n; j++) begin
          nxt[j] = slot[k][j] && !acc[j+1];
          if (j > 0) nxt[j] = nxt[j] || (slot[k][j-1] && acc[j]);
        end
        if (in_val[k] && acc[0]) begin
          nxt[0] = 1'b1;
          sb[k][(sb_head[k] + sb_cnt[k]) % 16] = in_msg[k] - 8'(n);
          sb_cnt[k] = sb_cnt[k] + 1;
        end
      end
      for (int j = 0; j < 8; j++) slot[k][j] = nxt[j];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; in_val[k] = 1'b1; in_msg[k] = 8'h55; out_rdy[k] = 1'b0;
    end
    tick();
    #1;
    for (int k = 0; k < NI; k++) begin
      total++;
      if (in_rdy[k] !== 1'b0) begin bad++; $display("FAIL reset_in_rdy inst=%0d got=%b want=0", k, in_rdy[k]); end
    end
    tick();
    for (int k = 0; k < NI; k++) begin rst[k] = 1'b0; in_val[k] = 1'b0; end
    #1;
    for (int k = 0; k < NI; k++) begin
      total++;
      if (out_val[k] !== 1'b0) begin bad++; $display("FAIL reset_out_val inst=%0d got=%b want=0", k, out_val[k]); end
      total++;
      if (out_msg[k] !== 8'h00) begin bad++; $display("FAIL reset_out_msg inst=%0d got=%h want=00", k, out_msg[k]); end
      total++;
      if (occ_of(k) !== 0) begin bad++; $display("FAIL reset_occ inst=%0d got=%0d want=0", k, occ_of(k)); end
      total++;
      if (in_rdy[k] !== 1'b1) begin bad++; $display("FAIL reset_in_rdy_after inst=%0d got=%b want=1", k, in_rdy[k]); end
    end
    tick();
  endtask

  task automatic test_idle();
    in_val[K2] = 1'b0; out_rdy[K2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (out_val[K2] !== 1'b0) begin bad++; $display("FAIL idle_out_val cyc=%0d got=%b want=0", c, out_val[K2]); end
      total++;
      if (occ_of(K2) !== 0) begin bad++; $display("FAIL idle_occ cyc=%0d got=%0d want=0", c, occ_of(K2)); end
      total++;
      if (in_rdy[K2] !== 1'b1) begin bad++; $display("FAIL idle_in_rdy cyc=%0d got=%b want=1", c, in_rdy[K2]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    out_rdy[K2] = 1'b1; in_val[K2] = 1'b1; in_msg[K2] = 8'h05;
    #1;
    total++;
    if (in_rdy[K2] !== 1'b1) begin bad++; $display("FAIL b2b_rdy0 got=%b want=1", in_rdy[K2]); end
    tick();
    in_msg[K2] = 8'h10;
    #1;
    total++;
    if (in_rdy[K2] !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%b want=1", in_rdy[K2]); end
    total++;
    if (out_val[K2] !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b want=0", out_val[K2]); end
    tick();
    in_val[K2] = 1'b0;
    #1;
    total++;
    if (out_val[K2] !== 1'b1 || out_msg[K2] !== 8'h03) begin
      bad++; $display("FAIL b2b_first got=%b/%h want=1/03", out_val[K2], out_msg[K2]);
    end
    tick();
    #1;
    total++;
    if (out_val[K2] !== 1'b1 || out_msg[K2] !== 8'h0E) begin
      bad++; $display("FAIL b2b_second got=%b/%h want=1/0e", out_val[K2], out_msg[K2]);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_val[K2] === 1'b1) extra++;
      tick();
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL b2b_extra_valid got=%0d want=0", extra); end
  endtask

  task automatic test_wrap();
    logic [7:0] ins [3];
    logic [7:0] exp [3];
    logic [7:0] got [$];
    int idx = 0;
    ins[0] = 8'h01; ins[1] = 8'h00; ins[2] = 8'hFF;
    exp[0] = 8'hFF; exp[1] = 8'hFE; exp[2] = 8'hFD;
    out_rdy[K2] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_val[K2] = (idx < 3);
      if (idx < 3) in_msg[K2] = ins[idx];
      #1;
      if (out_val[K2] === 1'b1) got.push_back(out_msg[K2]);
      if (in_val[K2] && in_rdy[K2] === 1'b1) idx++;
      tick();
    end
    in_val[K2] = 1'b0;
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL wrap_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL wrap_msg idx=%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3];
    logic [7:0] got [$];
    int sent = 2;
    exp[0] = 8'h1E; exp[1] = 8'h1F; exp[2] = 8'h20;
    out_rdy[K2] = 1'b0; in_val[K2] = 1'b1; in_msg[K2] = 8'h20;
    #1;
    total++;
    if (in_rdy[K2] !== 1'b1) begin bad++; $display("FAIL bp_rdy0 got=%b want=1", in_rdy[K2]); end
    tick();
    in_msg[K2] = 8'h21;
    #1;
    total++;
    if (in_rdy[K2] !== 1'b1) begin bad++; $display("FAIL bp_rdy1 got=%b want=1", in_rdy[K2]); end
    tick();
    in_msg[K2] = 8'h22;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (in_rdy[K2] !== 1'b0) begin bad++; $display("FAIL bp_full_rdy cyc=%0d got=%b want=0", c, in_rdy[K2]); end
      total++;
      if (occ_of(K2) !== 2) begin bad++; $display("FAIL bp_full_occ cyc=%0d got=%0d want=2", c, occ_of(K2)); end
      total++;
      if (out_val[K2] !== 1'b1 || out_msg[K2] !== 8'h1E) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/1e", c, out_val[K2], out_msg[K2]);
      end
      tick();
    end
    out_rdy[K2] = 1'b1;
    #1;
    total++;
    if (in_rdy[K2] !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got=%b want=1", in_rdy[K2]); end
    for (int c = 0; c < 10; c++) begin
      in_val[K2] = (sent < 3);
      #1;
      if (c == 1) begin
        total++;
        if (occ_of(K2) !== 2) begin bad++; $display("FAIL bp_simul_occ got=%0d want=2", occ_of(K2)); end
      end
      if (out_val[K2] === 1'b1) got.push_back(out_msg[K2]);
      if (in_val[K2] && in_rdy[K2] === 1'b1) sent++;
      tick();
    end
    in_val[K2] = 1'b0;
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++; $display("FAIL bp_msg idx=%0d got=%h want=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_bubble();
    logic [7:0] got [$];
    out_rdy[K2] = 1'b0; in_val[K2] = 1'b1; in_msg[K2] = 8'h40;
    tick();
    in_val[K2] = 1'b0;
    tick();
    #1;
    total++;
    if (occ_of(K2) !== 1 || out_val[K2] !== 1'b1 || out_msg[K2] !== 8'h3E) begin
      bad++; $display("FAIL bubble_setup got=%0d/%b/%h want=1/1/3e", occ_of(K2), out_val[K2], out_msg[K2]);
    end
    in_val[K2] = 1'b1; in_msg[K2] = 8'h41;
    #1;
    total++;
    if (in_rdy[K2] !== 1'b1) begin bad++; $display("FAIL bubble_in_rdy got=%b want=1", in_rdy[K2]); end
    tick();
    in_val[K2] = 1'b0;
    #1;
    total++;
    if (occ_of(K2) !== 2) begin bad++; $display("FAIL bubble_occ got=%0d want=2", occ_of(K2)); end
    total++;
    if (out_msg[K2] !== 8'h3E) begin bad++; $display("FAIL bubble_hold got=%h want=3e", out_msg[K2]); end
    out_rdy[K2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_val[K2] === 1'b1) got.push_back(out_msg[K2]);
      tick();
    end
    total++;
    if (got.size() != 2 || got[0] !== 8'h3E || got[1] !== 8'h3F) begin
      bad++; $display("FAIL bubble_drain got_n=%0d want=2 (3e,3f)", got.size());
    end
  endtask

  task automatic test_reset_mid(input int k);
    logic [7:0] got [$];
    logic [7:0] want;
    int stale = 0;
    int n;
    n = ns_of(k);
    want = (k == 0) ? 8'hFF : (k == 1) ? 8'hFE : 8'hFC;
    out_rdy[k] = 1'b0; in_val[k] = 1'b1; in_msg[k] = 8'h33;
    for (int c = 0; c < 3; c++) begin
      tick();
      in_msg[k] = in_msg[k] + 8'd1;
    end
    in_val[k] = 1'b0; rst[k] = 1'b1;
    #1;
    total++;
    if (in_rdy[k] !== 1'b0) begin bad++; $display("FAIL rmid_in_rdy inst=%0d got=%b want=0", k, in_rdy[k]); end
    tick();
    rst[k] = 1'b0;
    #1;
    total++;
    if (out_val[k] !== 1'b0 || occ_of(k) !== 0) begin
      bad++; $display("FAIL rmid_clear inst=%0d got=%b/%0d want=0/0", k, out_val[k], occ_of(k));
    end
    out_rdy[k] = 1'b1;
    for (int c = 0; c < n + 4; c++) begin
      #1;
      if (out_val[k] === 1'b1) stale++;
      tick();
    end
    total++;
    if (stale !== 0) begin bad++; $display("FAIL rmid_stale inst=%0d got=%0d want=0", k, stale); end
    in_val[k] = 1'b1; in_msg[k] = 8'h00;
    tick();
    in_val[k] = 1'b0;
    for (int c = 0; c < n + 3; c++) begin
      #1;
      if (out_val[k] === 1'b1) got.push_back(out_msg[k]);
      tick();
    end
    total++;
    if (got.size() != 1 || got[0] !== want) begin
      bad++; $display("FAIL rmid_zero inst=%0d got_n=%0d got=%h want=%h", k, got.size(),
                      (got.size() > 0) ? got[0] : 8'hxx, want);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int rdy_pct;
      rdy_pct = ((cyc / 150) % 3 == 0) ? 15 : ((cyc / 150) % 3 == 1) ? 60 : 95;
      for (int k = 0; k < NI; k++) begin
        rst[k]     = ($urandom_range(0, 99) == 0);
        in_val[k]  = ($urandom_range(0, 9) < 7);
        in_msg[k]  = 8'($urandom);
        out_rdy[k] = ($urandom_range(0, 99) < rdy_pct);
      end
      #1;
      for (int k = 0; k < NI; k++) begin
        total++;
        if (in_rdy[k] !== model_in_rdy(k)) begin
          bad++; $display("FAIL rnd_in_rdy inst=%0d cyc=%0d got=%b want=%b", k, cyc, in_rdy[k], model_in_rdy(k));
        end
        total++;
        if (out_val[k] !== model_out_val(k)) begin
          bad++; $display("FAIL rnd_out_val inst=%0d cyc=%0d got=%b want=%b", k, cyc, out_val[k], model_out_val(k));
        end
        total++;
        if (occ_of(k) !== model_occ(k)) begin
          bad++; $display("FAIL rnd_occ inst=%0d cyc=%0d got=%0d want=%0d", k, cyc, occ_of(k), model_occ(k));
        end
        if (model_out_val(k)) begin
          total++;
          if (sb_cnt[k] == 0 || out_msg[k] !== sb[k][sb_head[k]]) begin
            bad++; $display("FAIL rnd_out_msg inst=%0d cyc=%0d got=%h want=%h", k, cyc, out_msg[k], sb[k][sb_head[k]]);
          end
        end
      end
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0; in_val[k] = 1'b0; out_rdy[k] = 1'b1;
    end
    for (int c = 0; c < 6; c++) tick();
    for (int k = 0; k < NI; k++) begin
      total++;
      if (occ_of(k) !== 0 || sb_cnt[k] !== 0) begin
        bad++; $display("FAIL rnd_drain inst=%0d got=%0d want=0 (model left %0d)", k, occ_of(k), sb_cnt[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; in_val[k] = 1'b0; in_msg[k] = 8'h00; out_rdy[k] = 1'b0;
      sb_head[k] = 0; sb_cnt[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_idle();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_bubble();
    for (int k = 0; k < NI; k++) test_reset_mid(k);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
